// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants shared by the VGA sync path
package vga_timing_pkg;

  localparam int COORD_W = 10;
  localparam int DIV_W   = 4;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - timing stream from the sync generator to the pixel stage
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   p_tick;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   line_start;
  logic   frame_start;

  modport master (
    output hsync, vsync, video_on, p_tick, pixel_x, pixel_y, line_start, frame_start
  );

  modport slave (
    input hsync, vsync, video_on, p_tick, pixel_x, pixel_y, line_start, frame_start
  );

endinterface

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// rtl/vga_sync_gen_pixel_tick_gen.sv - system-clock divider producing the pixel-rate tick
module pixel_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // With PIX_DIV = 1 the counter sits at 0 and the tick is permanently high
  assign tick = (div_q == DIV_LAST);

  // Wrap to 0 on the tick, otherwise count up
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (tick) begin
      div_d = '0;
    end
  end

  // Divider phase register
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA horizontal/vertical timing generator with registered outputs
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_DISPLAY   = VGA_H_DISPLAY,
  parameter int   H_FRONT     = VGA_H_FRONT,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BACK      = VGA_H_BACK,
  parameter int   V_DISPLAY   = VGA_V_DISPLAY,
  parameter int   V_FRONT     = VGA_V_FRONT,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BACK      = VGA_V_BACK,
  parameter int   PIX_DIV     = 4,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  vga_sync_gen_if.master vid_o
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
  localparam coord_t HS_FIRST = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic   tick;
  coord_t h_cnt_q, h_cnt_d;
  coord_t v_cnt_q, v_cnt_d;
  logic   video_on_q, hsync_q, vsync_q;
  logic   p_tick_q, line_start_q, frame_start_q;

  pixel_tick_gen #(
    .PIX_DIV(PIX_DIV)
  ) u_pixel_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Next position: one pixel per tick, one line on each horizontal wrap
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + coord_t'(1);
      end else begin
        h_cnt_d = h_cnt_q + coord_t'(1);
      end
    end
  end

  // Decode from the next position so every output, p_tick included, changes on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      video_on_q    <= 1'b0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      p_tick_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      video_on_q    <= (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
      hsync_q       <= (h_cnt_d >= HS_FIRST && h_cnt_d <= HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_q       <= (v_cnt_d >= VS_FIRST && v_cnt_d <= VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      p_tick_q      <= tick;
      line_start_q  <= tick && (h_cnt_d == '0);
      frame_start_q <= tick && (h_cnt_d == '0) && (v_cnt_d == '0);
    end
  end

  assign vid_o.pixel_x     = h_cnt_q;
  assign vid_o.pixel_y     = v_cnt_q;
  assign vid_o.video_on    = video_on_q;
  assign vid_o.hsync       = hsync_q;
  assign vid_o.vsync       = vsync_q;
  assign vid_o.p_tick      = p_tick_q;
  assign vid_o.line_start  = line_start_q;
  assign vid_o.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed self-checking bench for vga_sync_gen
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if vid4 ();
  vga_sync_gen_if vid1 ();
  vga_sync_gen_if vids ();

  vga_sync_gen #(.PIX_DIV(4), .SYNC_ACTIVE(1'b0)) dut4 (
    .clk(clk), .rst(rst), .vid_o(vid4)
  );

  vga_sync_gen #(.PIX_DIV(1), .SYNC_ACTIVE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .vid_o(vid1)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .PIX_DIV(2), .SYNC_ACTIVE(1'b0)
  ) duts (
    .clk(clk), .rst(rst), .vid_o(vids)
  );

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (vid4.hsync !== 1'b1 || vid4.vsync !== 1'b1 || vid4.video_on !== 1'b0 ||
          vid4.pixel_x !== 10'd0 || vid4.pixel_y !== 10'd0 || vid4.p_tick !== 1'b0 ||
          vid4.line_start !== 1'b0 || vid4.frame_start !== 1'b0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got hs=%b vs=%b von=%b x=%0d y=%0d pt=%b ls=%b fs=%b want 1 1 0 0 0 0 0 0",
                 i, vid4.hsync, vid4.vsync, vid4.video_on, vid4.pixel_x, vid4.pixel_y,
                 vid4.p_tick, vid4.line_start, vid4.frame_start);
      end
    end
    checks++;
    if (vid1.hsync !== 1'b0 || vid1.vsync !== 1'b0) begin
      errors++;
      $display("FAIL reset_sync_active_high got hs=%b vs=%b want 0 0", vid1.hsync, vid1.vsync);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (vid4.video_on !== 1'b1 || vid4.pixel_x !== 10'd0 || vid4.pixel_y !== 10'd0 ||
        vid4.p_tick !== 1'b0 || vid4.frame_start !== 1'b0 || vid4.hsync !== 1'b1) begin
      errors++;
      $display("FAIL first_clk got von=%b x=%0d y=%0d pt=%b fs=%b hs=%b want 1 0 0 0 0 1",
               vid4.video_on, vid4.pixel_x, vid4.pixel_y, vid4.p_tick, vid4.frame_start, vid4.hsync);
    end
  endtask

  task automatic test_free_run_h();
    int ticks, hs_low, ls_cnt, shown;
    ticks = 0; hs_low = 0; ls_cnt = 0; shown = 0;
    apply_reset(2);
    for (int k = 1; k <= 6408; k++) begin
      int   xt, ex, ey;
      logic ept, evon, ehs, els;
      @(negedge clk);
      xt   = k / 4;
      ex   = xt % 800;
      ey   = xt / 800;
      ept  = (k % 4 == 0);
      evon = (ex < 640) && (ey < 480);
      ehs  = !(ex >= 656 && ex <= 751);
      els  = ept && (ex == 0);
      checks++;
      if (vid4.pixel_x !== ex[9:0] || vid4.pixel_y !== ey[9:0] || vid4.p_tick !== ept ||
          vid4.video_on !== evon || vid4.hsync !== ehs || vid4.vsync !== 1'b1 ||
          vid4.line_start !== els || vid4.frame_start !== 1'b0) begin
        errors++;
        if (shown < 5)
          $display("FAIL free_run k=%0d got x=%0d y=%0d pt=%b von=%b hs=%b vs=%b ls=%b fs=%b want x=%0d y=%0d pt=%b von=%b hs=%b vs=1 ls=%b fs=0",
                   k, vid4.pixel_x, vid4.pixel_y, vid4.p_tick, vid4.video_on, vid4.hsync, vid4.vsync,
                   vid4.line_start, vid4.frame_start, ex, ey, ept, evon, ehs, els);
        shown++;
      end
      if (k <= 3200) begin
        if (vid4.p_tick === 1'b1) ticks++;
        if (vid4.p_tick === 1'b1 && vid4.hsync === 1'b0) hs_low++;
      end
      if (vid4.line_start === 1'b1) ls_cnt++;
    end
    checks++;
    if (ticks !== 800) begin
      errors++;
      $display("FAIL ticks_per_line got %0d want 800", ticks);
    end
    checks++;
    if (hs_low !== 96) begin
      errors++;
      $display("FAIL hsync_width got %0d want 96", hs_low);
    end
    checks++;
    if (ls_cnt !== 2) begin
      errors++;
      $display("FAIL line_start_count got %0d want 2", ls_cnt);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(2);
    repeat (6002) @(negedge clk);
    checks++;
    if (vid4.pixel_x !== 10'd700 || vid4.pixel_y !== 10'd1) begin
      errors++;
      $display("FAIL mid_position got x=%0d y=%0d want 700 1", vid4.pixel_x, vid4.pixel_y);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (vid4.pixel_x !== 10'd0 || vid4.pixel_y !== 10'd0 || vid4.hsync !== 1'b1 ||
        vid4.vsync !== 1'b1 || vid4.line_start !== 1'b0 || vid4.frame_start !== 1'b0 ||
        vid4.p_tick !== 1'b0 || vid4.video_on !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got x=%0d y=%0d hs=%b vs=%b ls=%b fs=%b pt=%b von=%b want 0 0 1 1 0 0 0 0",
               vid4.pixel_x, vid4.pixel_y, vid4.hsync, vid4.vsync, vid4.line_start,
               vid4.frame_start, vid4.p_tick, vid4.video_on);
    end
    for (int k = 1; k <= 8; k++) begin
      logic ept;
      int   ex;
      @(negedge clk);
      ept = (k % 4 == 0);
      ex  = k / 4;
      checks++;
      if (vid4.p_tick !== ept || vid4.pixel_x !== ex[9:0] || vid4.pixel_y !== 10'd0 ||
          vid4.line_start !== 1'b0 || vid4.frame_start !== 1'b0 || vid4.hsync !== 1'b1) begin
        errors++;
        $display("FAIL mid_resume k=%0d got pt=%b x=%0d y=%0d ls=%b fs=%b hs=%b want pt=%b x=%0d y=0 ls=0 fs=0 hs=1",
                 k, vid4.p_tick, vid4.pixel_x, vid4.pixel_y, vid4.line_start, vid4.frame_start,
                 vid4.hsync, ept, ex);
      end
    end
  endtask

  task automatic test_pixdiv1();
    int run, best_run, best_start, run_start, ls_first, ls_second, shown;
    run = 0; best_run = 0; best_start = -1; run_start = -1;
    ls_first = -1; ls_second = -1; shown = 0;
    apply_reset(2);
    for (int k = 1; k <= 1700; k++) begin
      int   ex, ey;
      logic ehs, evon;
      @(negedge clk);
      ex   = k % 800;
      ey   = k / 800;
      ehs  = (ex >= 656 && ex <= 751);
      evon = (ex < 640);
      checks++;
      if (vid1.p_tick !== 1'b1 || vid1.pixel_x !== ex[9:0] || vid1.pixel_y !== ey[9:0] ||
          vid1.hsync !== ehs || vid1.vsync !== 1'b0 || vid1.video_on !== evon ||
          vid1.line_start !== (ex == 0) || vid1.frame_start !== 1'b0) begin
        errors++;
        if (shown < 5)
          $display("FAIL pixdiv1 k=%0d got pt=%b x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b want pt=1 x=%0d y=%0d hs=%b vs=0 von=%b",
                   k, vid1.p_tick, vid1.pixel_x, vid1.pixel_y, vid1.hsync, vid1.vsync,
                   vid1.video_on, vid1.line_start, vid1.frame_start, ex, ey, ehs, evon);
        shown++;
      end
      if (vid1.hsync === 1'b1) begin
        if (run == 0) run_start = int'(vid1.pixel_x);
        run++;
        if (run > best_run) begin
          best_run   = run;
          best_start = run_start;
        end
      end else begin
        run = 0;
      end
      if (vid1.line_start === 1'b1) begin
        if (ls_first < 0) ls_first = k;
        else if (ls_second < 0) ls_second = k;
      end
    end
    checks++;
    if (best_run !== 96 || best_start !== 656) begin
      errors++;
      $display("FAIL pixdiv1_hsync_run got len=%0d start=%0d want 96 656", best_run, best_start);
    end
    checks++;
    if (ls_second - ls_first !== 800) begin
      errors++;
      $display("FAIL pixdiv1_line_len got %0d want 800", ls_second - ls_first);
    end
  endtask

  task automatic test_frame();
    int fs_first, fs_second, fs_cnt, vs_low, shown;
    fs_first = -1; fs_second = -1; fs_cnt = 0; vs_low = 0; shown = 0;
    apply_reset(2);
    for (int k = 1; k <= 784; k++) begin
      int   xt, ex, ey;
      logic ept, evon, ehs, evs, els, efs;
      @(negedge clk);
      xt   = k / 2;
      ex   = xt % 15;
      ey   = (xt / 15) % 13;
      ept  = (k % 2 == 0);
      evon = (ex < 8) && (ey < 6);
      ehs  = !(ex >= 10 && ex <= 12);
      evs  = !(ey >= 8 && ey <= 9);
      els  = ept && (ex == 0);
      efs  = els && (ey == 0);
      checks++;
      if (vids.pixel_x !== ex[9:0] || vids.pixel_y !== ey[9:0] || vids.p_tick !== ept ||
          vids.video_on !== evon || vids.hsync !== ehs || vids.vsync !== evs ||
          vids.line_start !== els || vids.frame_start !== efs) begin
        errors++;
        if (shown < 5)
          $display("FAIL frame k=%0d got x=%0d y=%0d pt=%b von=%b hs=%b vs=%b ls=%b fs=%b want x=%0d y=%0d pt=%b von=%b hs=%b vs=%b ls=%b fs=%b",
                   k, vids.pixel_x, vids.pixel_y, vids.p_tick, vids.video_on, vids.hsync, vids.vsync,
                   vids.line_start, vids.frame_start, ex, ey, ept, evon, ehs, evs, els, efs);
        shown++;
      end
      if (k <= 390 && vids.p_tick === 1'b1 && vids.vsync === 1'b0) vs_low++;
      if (vids.frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
    end
    checks++;
    if (fs_cnt !== 2 || fs_second - fs_first !== 390) begin
      errors++;
      $display("FAIL frame_start got count=%0d gap=%0d want 2 390", fs_cnt, fs_second - fs_first);
    end
    checks++;
    if (vs_low !== 30) begin
      errors++;
      $display("FAIL vsync_ticks got %0d want 30", vs_low);
    end
  endtask

  initial begin
    test_reset();
    test_free_run_h();
    test_reset_mid();
    test_pixdiv1();
    test_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
